mux_arb_n: RTL



---
 rtl/mux_arb_n.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n
// Selects one of CHANNELS input channels (WIDTH bits each) and presents the
// chosen word on a registered output. Every side uses a valid/ready handshake.
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> round-robin arbitration with pointer ptr_q
//                   undefined -> fixed priority, channel 0 highest, no pointer
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected word
//   out_chan   index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
module mux_arb_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int IDXW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDXW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [IDXW-1:0]     out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;

  logic                can_load;
  logic                any_gnt;
  logic                xfer;
  logic [CHANNELS-1:0] grant;
  logic [IDXW-1:0]     gnt_idx;

`ifdef ROUND_ROBIN_EN
  logic [IDXW-1:0]     ptr_q, ptr_d;
  int                  rr_sum;
  logic [IDXW-1:0]     rr_idx;

  // Search upward from ptr_q. The wrap is done on a full-width integer so a
  // non-power-of-two channel count never forms an index past CHANNELS-1.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    rr_sum  = 0;
    rr_idx  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      rr_sum = int'(ptr_q) + k;
      if (rr_sum >= CHANNELS) rr_sum = rr_sum - CHANNELS;
      rr_idx = IDXW'(rr_sum);
      if (!any_gnt && in_valid[rr_idx]) begin
        any_gnt        = 1'b1;
        grant[rr_idx]  = 1'b1;
        gnt_idx        = rr_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDXW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic [IDXW-1:0] fp_idx;

  // Lowest-index valid channel wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    fp_idx  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      fp_idx = IDXW'(k);
      if (!any_gnt && in_valid[fp_idx]) begin
        any_gnt        = 1'b1;
        grant[fp_idx]  = 1'b1;
        gnt_idx        = fp_idx;
      end
    end
  end
`endif

  assign can_load = !out_valid_q || out_ready;

  // rst_n gates ready so no word is accepted in a reset cycle.
  assign in_ready = grant & {CHANNELS{can_load && rst_n}};
  assign xfer     = any_gnt && can_load && rst_n;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
